matrix_vector_loader_3x3: RTL
=============================

MATRIX_VECTOR_LOADER_3X3 -- requirements
Module: matrix_vector_loader_3x3

Interface
REQ-001 Parameter: KEEP_MATRIX, default 0, 1 = matrix retained across frames so a frame is vector-only until reload requested.
REQ-002 clk_i  input  1  single clock, all logic rising-edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 s_data_i  input  16  signed two's-complement input word.
REQ-005 s_valid_i  input  1  input word valid.
REQ-006 s_ready_o  output  1  block accepts word this cycle.
REQ-007 reload_i  input  1  single-cycle request to reload matrix at next frame boundary.
REQ-008 m_mat_o  output  144  3x3 matrix, row r at [143-48r -: 48], within row element c at [47-16c -: 16].
REQ-009 m_vec_o  output  48  3-vector, element c at [47-16c -: 16].
REQ-010 m_valid_o  output  1  m_mat_o/m_vec_o hold a complete frame.
REQ-011 m_ready_i  input  1  downstream multiply stage accepts frame.
REQ-012 frame_cnt_o  output  16  count of frames handed off, wraps 0xFFFF->0x0000.

Function
REQ-013 Input transfer occurs on a rising edge with s_valid_i=1 and s_ready_o=1; output transfer occurs on a rising edge with m_valid_o=1 and m_ready_i=1.
REQ-014 States: LOAD_M, LOAD_V, HOLD; 4-bit word index idx.
REQ-015 LOAD_M: each input transfer writes s_data_i to matrix element idx (row-major, idx 0 = row 0 col 0 = bits [143:128]), idx increments; transfer at idx=8 sets idx=0, next state LOAD_V.
REQ-016 LOAD_V: each input transfer writes s_data_i to vector element idx (idx 0 = bits [47:32]); transfer at idx=2 sets idx=0, next state HOLD.
REQ-017 s_ready_o = 1 in LOAD_M and LOAD_V, 0 in HOLD, 0 while rst_i=1; decoded from state only, never from m_ready_i.
REQ-018 m_valid_o = 1 exactly in HOLD; rises the cycle after the last vector word's transfer edge (latency 1 cycle).
REQ-019 HOLD: m_mat_o, m_vec_o stable; on output transfer frame_cnt_o increments by 1 and next state is LOAD_V if KEEP_MATRIX=1 and reload_pending=0, else LOAD_M; m_valid_o low the following cycle.
REQ-020 m_ready_i=1 without m_valid_o has no effect; m_valid_o, once high, stays high until transfer.
REQ-021 reload_pending set by reload_i=1 in any state except LOAD_M; cleared on entry to LOAD_M; reload_i ignored when KEEP_MATRIX=0.
REQ-022 reload_i=1 on the same edge as an output transfer in HOLD forces next state LOAD_M.
REQ-023 LOAD_V with KEEP_MATRIX=1 leaves m_mat_o unchanged; element registers not targeted by a write hold value.
REQ-024 m_mat_o/m_vec_o are written in place during load; contents meaningful only while m_valid_o=1.
REQ-025 Words are stored unmodified; no arithmetic, saturation or sign extension.
REQ-026 s_valid_i gaps stall the load; idx and state unchanged on cycles without transfer.

Reset
REQ-027 rst_i=1 at a clock edge: state=LOAD_M, idx=0, m_mat_o=0, m_vec_o=0, m_valid_o=0, frame_cnt_o=0, reload_pending=0; s_ready_o=0 while rst_i=1, 1 first cycle after release.
REQ-028 Reset mid-load or in HOLD discards partial/pending frame, no output transfer counted.

Verification
REQ-029 KEEP_MATRIX=0, words 1..12 back-to-back, m_ready_i=1 -> m_valid_o rises 1 cycle after word 12, m_mat_o=0x0001_0002_..._0009, m_vec_o=0x000A_000B_000C, frame_cnt_o=1 after transfer.
REQ-030 m_ready_i=0 for 10 cycles in HOLD with s_valid_i=1 -> s_ready_o=0, outputs stable, no words consumed; m_ready_i=1 -> single transfer.
REQ-031 KEEP_MATRIX=1, frame 1 of 12 words, then 3 words 0x7FFF,0x8000,0xFFFF -> second frame m_mat_o unchanged, m_vec_o=0x7FFF_8000_FFFF.
REQ-032 KEEP_MATRIX=1, reload_i pulsed during LOAD_V -> current frame completes 3 words, following frame requires 12 words.
REQ-033 rst_i pulsed after 5 matrix words -> next 12 words form a fresh frame from idx 0, frame_cnt_o=0 before handoff.
REQ-034 frame_cnt_o preset by 65535 transfers -> next transfer wraps to 0x0000.

Source files
------------

// File: rtl/matrix_vector_loader_3x3.sv
// 3x3 matrix / 3-vector frame loader.
// Collects a stream of signed 16-bit words into a row-major 3x3 matrix
// followed by a 3-vector, then presents the complete frame to a downstream
// multiply stage with a valid/ready handshake. With KEEP_MATRIX=1 the matrix
// is retained across frames, so later frames only carry the vector until a
// reload is requested.
module matrix_vector_loader_3x3 #(
  parameter bit KEEP_MATRIX = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [15:0]  s_data_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic         reload_i,
  output logic [143:0] m_mat_o,
  output logic [47:0]  m_vec_o,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [15:0]  frame_cnt_o
);

  typedef enum logic [1:0] {
    LOAD_M = 2'd0,
    LOAD_V = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t      state_reg;
  logic [3:0]  idx_reg;
  logic        reload_pending_reg;
  logic [15:0] frame_cnt_reg;

  logic in_xfer;
  logic out_xfer;
  logic reload_req;
  logic mat_wr;
  logic vec_wr;

  // Ready is a pure decode of the state, forced low while reset is held.
  assign s_ready_o   = ~rst_i && (state_reg != HOLD);
  assign m_valid_o   = (state_reg == HOLD);
  assign frame_cnt_o = frame_cnt_reg;

  assign in_xfer    = s_valid_i && s_ready_o;
  assign out_xfer   = (state_reg == HOLD) && m_ready_i;
  // Reload requests only matter when the matrix is normally retained.
  assign reload_req = KEEP_MATRIX && reload_i;
  assign mat_wr     = in_xfer && (state_reg == LOAD_M);
  assign vec_wr     = in_xfer && (state_reg == LOAD_V);

  // Frame sequencing: word index, state, reload request and handoff counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg          <= LOAD_M;
      idx_reg            <= 4'd0;
      reload_pending_reg <= 1'b0;
      frame_cnt_reg      <= 16'd0;
    end else begin
      case (state_reg)
        LOAD_M: begin
          if (in_xfer) begin
            if (idx_reg == 4'd8) begin
              idx_reg   <= 4'd0;
              state_reg <= LOAD_V;
            end else begin
              idx_reg <= idx_reg + 4'd1;
            end
          end
        end
        LOAD_V: begin
          if (reload_req) begin
            reload_pending_reg <= 1'b1;
          end
          if (in_xfer) begin
            if (idx_reg == 4'd2) begin
              idx_reg   <= 4'd0;
              state_reg <= HOLD;
            end else begin
              idx_reg <= idx_reg + 4'd1;
            end
          end
        end
        HOLD: begin
          if (out_xfer) begin
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
            // A reload arriving on the handoff edge itself still forces a
            // full matrix load for the next frame.
            if (KEEP_MATRIX && !reload_pending_reg && !reload_req) begin
              state_reg <= LOAD_V;
            end else begin
              state_reg          <= LOAD_M;
              reload_pending_reg <= 1'b0;
            end
          end else if (reload_req) begin
            reload_pending_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= LOAD_M;
          idx_reg   <= 4'd0;
        end
      endcase
    end
  end

  // One register per matrix element; element gi sits at row gi/3, col gi%3.
  for (genvar gi = 0; gi < 9; gi++) begin : g_mat
    logic [15:0] elem_reg;

    // Capture the word addressed by idx while loading the matrix.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        elem_reg <= 16'd0;
      end else if (mat_wr && (idx_reg == 4'(gi))) begin
        elem_reg <= s_data_i;
      end
    end

    assign m_mat_o[143-16*gi -: 16] = elem_reg;
  end

  // One register per vector element.
  for (genvar gi = 0; gi < 3; gi++) begin : g_vec
    logic [15:0] elem_reg;

    // Capture the word addressed by idx while loading the vector.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        elem_reg <= 16'd0;
      end else if (vec_wr && (idx_reg == 4'(gi))) begin
        elem_reg <= s_data_i;
      end
    end

    assign m_vec_o[47-16*gi -: 16] = elem_reg;
  end

endmodule
